spi_burst_master: RTL and testbench
===================================

# spi_burst_master

Parametrised SPI master for the SD controller: generates SCLK internally from `clk` through a programmable divider, supports all four CPOL/CPHA modes, MSB- or LSB-first ordering and a configurable word width. Multi-word bursts keep chip select asserted. Words arrive on a valid/ready command port and received words leave on a one-cycle `rx_valid` strobe. It replaces the fixed 8-bit transactor, which relied on externally generated SCLK edge strobes.

## Interface

- `DATA_W`, 8: bits per word, ≥2.
- `DIV_W`, 8: width of `clk_div`.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clk_div`  in  DIV_W  SCLK half-period minus 1, in `clk` cycles (H = `clk_div`+1).
- `cpol`  in  1  SCLK idle level.
- `cpha`  in  1  0 = sample on leading edge; 1 = sample on trailing edge.
- `lsb_first`  in  1  bit order.
- `cmd_valid`  in  1  word offered.
- `cmd_ready`  out  1  word accepted when `cmd_valid && cmd_ready`.
- `cmd_data`  in  DATA_W  word to transmit.
- `cmd_last`  in  1  deassert CS after this word.
- `rx_valid`  out  1  one-cycle strobe, received word valid.
- `rx_data`  out  DATA_W  last received word; held until the next strobe.
- `busy`  out  1  high whenever CS is asserted or the CS gap is running.
- `spi_sclk`  out  1  serial clock.
- `spi_mosi`  out  1  serial data out.
- `spi_miso`  in  1  serial data in, assumed already synchronous to `clk`.
- `spi_cs_n`  out  1  chip select, active low.

## Operation

- **States:** IDLE, SHIFT, NEXT, HOLD, GAP.
- **IDLE**
  - `cmd_ready`=1, `spi_cs_n`=1, `spi_mosi`=1.
  - `spi_sclk` is registered from `cpol` every cycle.
  - On accept: latch `clk_div`, `cpol`, `cpha`, `lsb_first` (frozen until return to IDLE); load the shift register; drive `spi_cs_n`=0; go to SHIFT.
- **SHIFT**
  - Produces 2·DATA_W SCLK edges. Edge k (k=1..2·DATA_W) occurs k·H cycles after the accept edge.
  - Odd k is a leading edge (SCLK leaves `cpol`); even k is a trailing edge.
  - `cpha`=0:
    - First bit appears on MOSI at the accept edge.
    - MISO is sampled on odd edges.
    - Next MOSI bit is driven on even edges k<2·DATA_W.
  - `cpha`=1:
    - MOSI is driven on odd edges.
    - MISO is sampled on even edges.
    - MOSI holds its previous value (1 for the first word) until edge 1.
  - A sample captures `spi_miso` at the same `clk` edge on which `spi_sclk` toggles.
  - Bit order: MSB first unless `lsb_first`. The received word uses the same order (first sampled bit → MSB when `lsb_first`=0).
  - On the `clk` edge producing edge 2·DATA_W:
    - `rx_data` updates, including a bit sampled on that edge.
    - `rx_valid` is asserted for one cycle.
    - Next state is HOLD if the word's latched `cmd_last`=1, else NEXT.
- **NEXT**
  - CS held low; SCLK stays at `cpol`; `cmd_ready`=1.
  - Waits indefinitely.
  - On accept: load the word; edges are timed relative to this accept exactly as in SHIFT. Config stays frozen.
- **HOLD:** H cycles with CS low, then `spi_cs_n`=1 and go to GAP.
- **GAP:** H cycles with CS high and `cmd_ready`=0, then IDLE.
- **Simultaneous events:** `cmd_valid` is ignored while `cmd_ready`=0. Input changes to config while `busy` have no effect.
- **Reset, including mid-word:** all outputs return to reset values immediately and asynchronously. No `rx_valid` is issued for a partial word.

## Timing

- **Reset values:** `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=1, `rx_valid`=0, `rx_data`=0, `busy`=0. `cmd_ready`=1 after release.
- **`cmd_ready`:** combinational from state only.
- **Word latency:** accept → `rx_valid` = 2·DATA_W·H cycles.
- **CS timing:**
  - CS assert to first edge: H cycles.
  - Last edge to CS deassert: H cycles.
  - CS high: at least H cycles.
- **Divider:** `clk_div`=0 gives SCLK = `clk`/2. The divider counter is DIV_W bits and wraps only through reload; all-ones is legal.
- **Back-to-back bursts:** a word accepted in NEXT on the cycle after `rx_valid` keeps SCLK gap-free apart from the H-cycle setup half-period.

## Test plan

- **Mode 0, single word:** `clk_div`=3, `cmd_data`=0x55, `cmd_last`=1, slave returns 0xA5.
  - Required: 8 rising edges spaced 8 cycles apart.
  - MOSI shows 0,1,0,1,… MSB first.
  - `rx_valid` at accept+64 with `rx_data`=0xA5.
  - CS low for 68 cycles.
- **Mode 3 burst:** words 0x3C then 0x4A (`cmd_last` only on the second), slave returns 0xC3 then 0xB4.
  - Required: CS stays low across both words.
  - Two `rx_valid` strobes carrying 0xC3 and 0xB4.
  - SCLK idles high.
- **LSB-first, mode 1:** `clk_div`=0, `cmd_data`=0x01, slave sends MISO 1 then seven 0s.
  - Required: MOSI first bit is 1.
  - `rx_data`=0x01.
  - SCLK period is 2 cycles.
- **Config freeze:** toggle `cpol`/`clk_div` mid-word → edge spacing and idle level unchanged until IDLE is reached again.
- **Reset mid-word:** assert `rst_n`=0 after edge 5.
  - Required: `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=1 immediately.
  - No `rx_valid`.
  - Next transfer completes correctly.
- **DATA_W=16:** `cmd_data`=0xBEEF, slave returns 0x1234 → 32 edges, `rx_data`=0x1234.

Source files
------------

// File: rtl/spi_burst_master.sv
// SPI master with internal SCLK divider, all four CPOL/CPHA modes, selectable bit order and
// multi-word bursts under a single chip select.
module spi_burst_master #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_last,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_cs_n
);

  localparam int unsigned EdgeW = $clog2(2 * DATA_W + 1);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StShift, StNext, StHold, StGap} state_e;

  state_e            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  cnt_q;
  logic              cpol_q;
  logic              cpha_q;
  logic              lsb_q;
  logic              last_q;
  logic [EdgeW-1:0]  edge_q;
  logic [DATA_W-1:0] tx_sr_q;
  logic [DATA_W-1:0] rx_sr_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              cs_n_q;
  logic              sclk_q;
  logic              mosi_q;

  logic              accept;
  logic              in_idle;
  logic [DIV_W-1:0]  eff_div;
  logic              eff_cpha;
  logic              eff_lsb;
  logic              tick;
  logic              odd_edge;
  logic              last_edge;
  logic              sample_now;
  logic              drive_now;
  logic              tx_head;
  logic [DATA_W-1:0] tx_shift;
  logic              cmd_head;
  logic [DATA_W-1:0] cmd_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_next;

  assign in_idle   = (state_q == StIdle);
  assign cmd_ready = in_idle || (state_q == StNext);
  assign busy      = !in_idle;
  assign accept    = cmd_valid && cmd_ready;

  // Config comes from the ports only on the first word of a burst; later words reuse the latch.
  assign eff_div  = in_idle ? clk_div   : div_q;
  assign eff_cpha = in_idle ? cpha      : cpha_q;
  assign eff_lsb  = in_idle ? lsb_first : lsb_q;

  assign tick       = (cnt_q == '0);
  assign odd_edge   = ~edge_q[0];
  assign last_edge  = (edge_q == LastEdge);
  assign sample_now = tick && (odd_edge ^ cpha_q);
  assign drive_now  = tick && (cpha_q ? odd_edge : (!odd_edge && !last_edge));

  assign tx_head   = lsb_q ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
  assign tx_shift  = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
  assign cmd_head  = eff_lsb ? cmd_data[0] : cmd_data[DATA_W-1];
  assign cmd_shift = eff_lsb ? (cmd_data >> 1) : (cmd_data << 1);
  assign rx_shift  = lsb_q ? {spi_miso, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], spi_miso};
  // The final edge may itself be a sample edge (cpha=1), so the word is taken from rx_next.
  assign rx_next   = sample_now ? rx_shift : rx_sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      cnt_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      last_q     <= 1'b0;
      edge_q     <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b1;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          sclk_q <= cpol;
          mosi_q <= 1'b1;
          cs_n_q <= 1'b1;
          if (cmd_valid) begin
            div_q  <= clk_div;
            cpol_q <= cpol;
            cpha_q <= cpha;
            lsb_q  <= lsb_first;
          end
        end
        StShift: begin
          if (tick) begin
            cnt_q  <= div_q;
            edge_q <= edge_q + EdgeW'(1);
            sclk_q <= last_edge ? cpol_q : ~sclk_q;
            if (sample_now) begin
              rx_sr_q <= rx_shift;
            end
            if (drive_now) begin
              mosi_q  <= tx_head;
              tx_sr_q <= tx_shift;
            end
            if (last_edge) begin
              rx_data_q  <= rx_next;
              rx_valid_q <= 1'b1;
              state_q    <= last_q ? StHold : StNext;
            end
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        StNext: begin
          sclk_q <= cpol_q;
        end
        StHold: begin
          sclk_q <= cpol_q;
          if (tick) begin
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b1;
            cnt_q   <= div_q;
            state_q <= StGap;
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        StGap: begin
          sclk_q <= cpol_q;
          if (tick) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase

      // Word load shared by IDLE and NEXT; overrides the per-state defaults above.
      if (accept) begin
        cnt_q   <= eff_div;
        edge_q  <= '0;
        last_q  <= cmd_last;
        cs_n_q  <= 1'b0;
        state_q <= StShift;
        if (eff_cpha) begin
          tx_sr_q <= cmd_data;
        end else begin
          tx_sr_q <= cmd_shift;
          mosi_q  <= cmd_head;
        end
      end
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_burst_master.sv
// Scoreboard bench for spi_burst_master: 8- and 16-bit instances share one SPI slave model.
module tb_spi_burst_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  clk_div;
  logic        cpol, cpha, lsb_first;
  logic        cmd_valid, cmd_last;
  logic [15:0] cmd_data;
  logic        spi_miso;
  logic        sel16;

  logic        ready8, rxv8, busy8, sclk8, mosi8, csn8;
  logic [7:0]  rxd8;
  logic        ready16, rxv16, busy16, sclk16, mosi16, csn16;
  logic [15:0] rxd16;
  logic        cv8, cv16;

  assign cv8  = cmd_valid & ~sel16;
  assign cv16 = cmd_valid & sel16;

  spi_burst_master #(.DATA_W(8), .DIV_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .cmd_valid(cv8), .cmd_ready(ready8), .cmd_data(cmd_data[7:0]),
    .cmd_last(cmd_last), .rx_valid(rxv8), .rx_data(rxd8), .busy(busy8), .spi_sclk(sclk8),
    .spi_mosi(mosi8), .spi_miso(spi_miso), .spi_cs_n(csn8)
  );

  spi_burst_master #(.DATA_W(16), .DIV_W(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .cmd_valid(cv16), .cmd_ready(ready16), .cmd_data(cmd_data),
    .cmd_last(cmd_last), .rx_valid(rxv16), .rx_data(rxd16), .busy(busy16), .spi_sclk(sclk16),
    .spi_mosi(mosi16), .spi_miso(spi_miso), .spi_cs_n(csn16)
  );

  logic        m_ready, m_rx_valid, m_busy, m_sclk, m_mosi, m_cs_n;
  logic [15:0] m_rx_data;
  assign m_ready    = sel16 ? ready16 : ready8;
  assign m_rx_valid = sel16 ? rxv16 : rxv8;
  assign m_busy     = sel16 ? busy16 : busy8;
  assign m_sclk     = sel16 ? sclk16 : sclk8;
  assign m_mosi     = sel16 ? mosi16 : mosi8;
  assign m_cs_n     = sel16 ? csn16 : csn8;
  assign m_rx_data  = sel16 ? rxd16 : {8'h00, rxd8};

  typedef struct {logic [15:0] data; int t;} exp_t;
  typedef struct {int t; logic lvl;} edge_t;

  exp_t        rx_q[$];
  edge_t       edge_q[$];
  int          csr_q[$];
  logic [15:0] tx_q[$];
  logic [15:0] slv_q[$];

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   wordw = 8;
  int   b_div = 0;
  logic b_cpol = 1'b0, b_cpha = 1'b0, b_lsb = 1'b0;
  logic frozen = 1'b0;
  logic in_rst = 1'b1;
  logic [15:0] btx[4];
  logic [15:0] brx[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic first_bit(input logic [15:0] d);
    return b_lsb ? d[0] : d[wordw-1];
  endfunction

  task automatic scramble();
    if (frozen) begin
      clk_div   = 8'($urandom);
      cpol      = 1'($urandom);
      cpha      = 1'($urandom);
      lsb_first = 1'($urandom);
    end
  endtask

  // Offer one word, then record every consequence the spec predicts from its accept edge.
  task automatic send_word(input logic [15:0] d, input logic [15:0] sw, input logic last,
                           output int acc);
    int   h, w, budget;
    logic lvl;
    h = b_div + 1;
    w = wordw;
    cmd_data  = d;
    cmd_last  = last;
    cmd_valid = 1'b1;
    budget = 0;
    while (!m_ready && budget < 20000) begin
      @(posedge clk); #1;
      budget++;
      scramble();
    end
    acc = cyc + 1;
    if (!m_ready) begin
      check("accept timeout", m_ready, 1);
      cmd_valid = 1'b0;
    end else begin
      for (int k = 1; k <= 2 * w; k++) begin
        lvl = (k % 2 == 1) ? ~b_cpol : b_cpol;
        edge_q.push_back('{acc + k * h, lvl});
      end
      rx_q.push_back('{sw, acc + 2 * w * h});
      tx_q.push_back(d);
      slv_q.push_back(sw);
      if (last) csr_q.push_back(acc + 2 * w * h + h);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic run_burst(input logic s16, input int div, input logic cp, input logic ch,
                           input logic lsb, input int n);
    int acc, budget, g;
    sel16  = s16;
    wordw  = s16 ? 16 : 8;
    b_div  = div;
    b_cpol = cp;
    b_cpha = ch;
    b_lsb  = lsb;
    clk_div = 8'(div); cpol = cp; cpha = ch; lsb_first = lsb;
    for (int i = 0; i < n; i++) begin
      send_word(btx[i], brx[i], i == n - 1, acc);
      frozen = 1'b1;
      g = $urandom_range(0, 3);
      repeat (g) begin
        @(posedge clk); #1;
        scramble();
      end
    end
    budget = 0;
    while (m_busy && budget < 20000) begin
      @(posedge clk); #1;
      budget++;
      scramble();
    end
    frozen = 1'b0;
    check("burst returns to idle", m_busy, 0);
    check("ready in idle", m_ready, 1);
  endtask

  task automatic reset_mid_word();
    int acc, budget;
    run_cfg_mode0();
    send_word(16'h0081, 16'h00C6, 1'b1, acc);
    budget = 0;
    while (cyc < acc + 5 * (b_div + 1) && budget < 1000) begin
      @(posedge clk); #1;
      budget++;
    end
    in_rst = 1'b1;
    rst_n  = 1'b0;
    #1;
    check("reset cs_n", m_cs_n, 1);
    check("reset sclk", m_sclk, 0);
    check("reset mosi", m_mosi, 1);
    check("reset rx_valid", m_rx_valid, 0);
    check("reset busy", m_busy, 0);
    edge_q.delete(); rx_q.delete(); csr_q.delete(); tx_q.delete(); slv_q.delete();
    repeat (3) begin
      @(posedge clk); #1;
      check("rx_valid held in reset", m_rx_valid, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_rst = 1'b0;
    check("ready after reset", m_ready, 1);
  endtask

  task automatic run_cfg_mode0();
    sel16 = 1'b0; wordw = 8;
    b_div = 2; b_cpol = 1'b0; b_cpha = 1'b0; b_lsb = 1'b0;
    clk_div = 8'd2; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
  endtask

  // SPI slave: returns its queued word bit by bit and captures MOSI on the sampling edges.
  initial begin
    int          se, s, j;
    logic [15:0] cap, exp_tx, tmp;
    logic        p_sclk, p_cs;
    se = 0; cap = '0; p_sclk = 1'b0; p_cs = 1'b1; spi_miso = 1'b0;
    forever begin
      @(posedge clk); #3;
      if (!rst_n || in_rst || m_cs_n) begin
        se  = 0;
        cap = '0;
      end else if (p_cs) begin
        if (tx_q.size() > 0)
          check("mosi before edge 1", m_mosi, b_cpha ? 1'b1 : first_bit(tx_q[0]));
      end else if (m_sclk !== p_sclk) begin
        se++;
        if ((se % 2 == 1) != b_cpha) begin
          j = (se - 1) / 2;
          if (b_lsb) cap[j] = m_mosi;
          else cap[wordw - 1 - j] = m_mosi;
        end
        if (se == 2 * wordw) begin
          if (tx_q.size() > 0) begin
            exp_tx = tx_q.pop_front();
            check("mosi word", cap, exp_tx);
          end
          if (slv_q.size() > 0) tmp = slv_q.pop_front();
          se  = 0;
          cap = '0;
        end
      end
      p_sclk = m_sclk;
      p_cs   = m_cs_n;
      s = b_cpha ? se / 2 : (se + 1) / 2;
      if (slv_q.size() > 0 && s < wordw) spi_miso = b_lsb ? slv_q[0][s] : slv_q[0][wordw - 1 - s];
      else spi_miso = 1'b0;
    end
  end

  // Monitor: pops expectations whenever the DUT shows an edge, a strobe or a CS change.
  initial begin
    logic  p_sclk, p_cs;
    edge_t e;
    exp_t  x;
    int    t;
    p_sclk = 1'b0; p_cs = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (rst_n && !in_rst) begin
        if (!p_cs && !m_cs_n && m_sclk !== p_sclk) begin
          if (edge_q.size() == 0) check("unexpected sclk edge", m_sclk, p_sclk);
          else begin
            e = edge_q.pop_front();
            check("sclk edge cycle", cyc, e.t);
            check("sclk edge level", m_sclk, e.lvl);
          end
        end
        if (p_cs && !m_cs_n && edge_q.size() > 0)
          check("cs to first edge", edge_q[0].t - cyc, b_div + 1);
        if (m_rx_valid) begin
          if (rx_q.size() == 0) check("unexpected rx_valid", m_rx_valid, 0);
          else begin
            x = rx_q.pop_front();
            check("rx data", m_rx_data, x.data);
            check("rx cycle", cyc, x.t);
          end
        end
        if (!p_cs && m_cs_n) begin
          if (csr_q.size() == 0) check("unexpected cs rise", m_cs_n, 0);
          else begin
            t = csr_q.pop_front();
            check("cs rise cycle", cyc, t);
            check("sclk idle level", m_sclk, b_cpol);
          end
        end
      end
      p_sclk = m_sclk;
      p_cs   = m_cs_n;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic s16;
    int   n;
    rst_n = 1'b0; sel16 = 1'b0; cmd_valid = 1'b0; cmd_last = 1'b0; cmd_data = '0;
    clk_div = '0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset cs_n", m_cs_n, 1);
    check("reset sclk", m_sclk, 0);
    check("reset mosi", m_mosi, 1);
    check("reset rx_valid", m_rx_valid, 0);
    check("reset rx_data", m_rx_data, 0);
    check("reset busy", m_busy, 0);
    check("reset cs_n 16", csn16, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_rst = 1'b0;
    check("ready after reset", m_ready, 1);

    btx[0] = 16'h0055; brx[0] = 16'h00A5;
    run_burst(1'b0, 3, 1'b0, 1'b0, 1'b0, 1);

    btx[0] = 16'h003C; brx[0] = 16'h00C3;
    btx[1] = 16'h004A; brx[1] = 16'h00B4;
    run_burst(1'b0, 1, 1'b1, 1'b1, 1'b0, 2);

    btx[0] = 16'h0001; brx[0] = 16'h0001;
    run_burst(1'b0, 0, 1'b0, 1'b1, 1'b1, 1);

    reset_mid_word();

    btx[0] = 16'h00E7; brx[0] = 16'h0019;
    run_burst(1'b0, 2, 1'b0, 1'b0, 1'b0, 1);

    btx[0] = 16'hBEEF; brx[0] = 16'h1234;
    run_burst(1'b1, 1, 1'b0, 1'b0, 1'b0, 1);

    btx[0] = 16'h00D2; brx[0] = 16'h004B;
    run_burst(1'b0, 255, 1'b1, 1'b0, 1'b0, 1);

    for (int it = 0; it < 40; it++) begin
      s16 = ($urandom_range(0, 3) == 0);
      n   = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        btx[i] = s16 ? 16'($urandom) : {8'h00, 8'($urandom)};
        brx[i] = s16 ? 16'($urandom) : {8'h00, 8'($urandom)};
      end
      run_burst(s16, $urandom_range(0, 4), 1'($urandom), 1'($urandom), 1'($urandom), n);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    #1;
    check("outstanding expectations", edge_q.size() + rx_q.size() + csr_q.size() + tx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
